timer_counter: RTL

Memory-mapped 32-bit down-counter timer occupying one of the TIMER0/TIMER1 address windows. It is the peripheral that feeds the data-extension stage: the bridge returns `data_out` from here as that stage's raw load data. It also raises an interrupt request toward the interrupt/CP0 logic. Software accesses it only by aligned word loads and stores; the extension stage already raises an exception for any byte or halfword access to a timer window.

---
 rtl/timer_counter_pkg.sv | 38 +++
 rtl/timer_counter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg
//   Shared constants for the memory-mapped down-counter timer: register
//   offsets (ADDR[3:2]), FSM state encodings, MODE values and CTRL bit
//   positions. Imported by timer_counter.
package timer_counter_pkg;

    // Register offsets, decoded from ADDR[3:2]
    localparam logic [1:0] REG_CTRL   = 2'b00;
    localparam logic [1:0] REG_PRESET = 2'b01;
    localparam logic [1:0] REG_COUNT  = 2'b10;
    localparam logic [1:0] REG_RSVD   = 2'b11;

    // FSM state encodings
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CNT  = 2'b10,
        ST_INT  = 2'b11
    } state_t;

    // MODE values; 2'b10 and 2'b11 are reserved and behave as one-shot
    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    // CTRL bit indices
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Stored CTRL bits; field order matches the bit indices above
    typedef struct packed {
        logic       im;    // [3]
        logic [1:0] mode;  // [2:1]
        logic       en;    // [0]
    } ctrl_t;

endpackage

// File: rtl/timer_counter.sv
// timer_counter
//   32-bit memory-mapped down-counter timer with interrupt request.
//   Registers (ADDR[3:2]): 00 CTRL {IM, MODE[1:0], EN}, 01 PRESET,
//   10 COUNT (read-only), 11 reserved (reads 0, writes ignored).
//   Ports:
//     clk      system clock
//     reset    asynchronous, active-high reset
//     WE       write strobe (already window-qualified by the bridge)
//     ADDR     byte address, only ADDR[3:2] decoded
//     data_in  store data
//     data_out combinational read data of the selected register
//     IRQ      irq_flag & CTRL.IM
//
// Bus handshake: there is no valid/ready pair on this port. A write is
// accepted unconditionally on every rising edge where WE=1; reads are
// combinational from ADDR with zero latency and never stall.
module timer_counter
    import timer_counter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] ADDR,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        IRQ
);

    // Registered state; state_q is the FSM state visible to checkers
    state_t      state_q, state_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic [1:0]  reg_sel;
    assign reg_sel = ADDR[3:2];

    // Bits outside the decoded fields are intentionally ignored
    logic unused_bits;
    assign unused_bits = ^{ADDR[31:4], ADDR[1:0], data_in[31:4]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        // FSM acts on the CTRL value held before this edge
        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // Covers PRESET=0 too, so COUNT never wraps
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                if (ctrl_q.mode == MODE_PERIODIC) begin
                    irq_flag_d = 1'b0;
                    state_d    = ST_LOAD;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Software writes are applied last so they override the FSM's
        // EN clear on a colliding edge; CTRL/PRESET writes acknowledge
        // a pending interrupt.
        if (WE) begin
            unique case (reg_sel)
                REG_CTRL: begin
                    ctrl_d     = ctrl_t'(data_in[CTRL_IM:CTRL_EN]);
                    irq_flag_d = 1'b0;
                end
                REG_PRESET: begin
                    preset_d   = data_in;
                    irq_flag_d = 1'b0;
                end
                REG_COUNT, REG_RSVD: ;
                default: ;
            endcase
        end
    end

    always_comb begin
        data_out = '0;
        unique case (reg_sel)
            REG_CTRL:   data_out = {28'd0, ctrl_q.im, ctrl_q.mode[CTRL_MODE_HI-1], ctrl_q.mode[CTRL_MODE_LO-1], ctrl_q.en};
            REG_PRESET: data_out = preset_q;
            REG_COUNT:  data_out = count_q;
            REG_RSVD:   data_out = '0;
            default:    data_out = '0;
        endcase
    end

    assign IRQ = irq_flag_q & ctrl_q.im;

endmodule
